// File: rtl/maquina_cafe_param.sv
// Coin-operated drink controller: credit handling, five priced recipes, timed valve
// sequencing, change return and a two-digit 7-segment credit display.
module maquina_cafe_param #(
    parameter int         CREDIT_W    = 11,
    parameter int         COIN_LO     = 100,
    parameter int         COIN_HI     = 500,
    parameter int         MAX_CREDIT  = 1500,
    parameter int         PRICE_E     = 300,
    parameter int         PRICE_L     = 500,
    parameter int         PRICE_X     = 550,
    parameter int         PRICE_M     = 600,
    parameter int         PRICE_A     = 400,
    parameter logic [4:0] RCP_E       = 5'b11001,
    parameter logic [4:0] RCP_L       = 5'b11101,
    parameter logic [4:0] RCP_X       = 5'b11101,
    parameter logic [4:0] RCP_M       = 5'b11111,
    parameter logic [4:0] RCP_A       = 5'b11000,
    parameter int         STEP_CYCLES = 50_000_000,
    parameter int         DONE_CYCLES = 50_000_000
) (
    input  logic                clk_50Mhz,
    input  logic                rst,
    input  logic                e,
    input  logic                l,
    input  logic                x,
    input  logic                m,
    input  logic                a,
    input  logic                C,
    input  logic                Q,
    input  logic                cancel,
    output logic                bebidaLista,
    output logic                agua,
    output logic                cafe,
    output logic                leche,
    output logic                choco,
    output logic                azucar,
    output logic                coin_reject,
    output logic                sel_denied,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amount,
    output logic [CREDIT_W-1:0] credit,
    output logic [6:0]          hex1,
    output logic [6:0]          hex2
);
    localparam int MAXC = (STEP_CYCLES > DONE_CYCLES) ? STEP_CYCLES : DONE_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int XW   = CREDIT_W + 1;
    localparam logic [CW-1:0] STEP_LD = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] DONE_LD = CW'(DONE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, STEP, DONE, CHANGE} state_t;

    state_t              state_q;
    logic [CREDIT_W-1:0] credit_q, change_amount_q;
    logic [4:0]          sel_prev_q, valve_q, rem_q;
    logic [2:0]          ctl_prev_q;
    logic [CW-1:0]       cnt_q;
    logic                bebida_q, coin_reject_q, sel_denied_q, change_valid_q;

    logic [4:0]    sel_rise, rcp_sel, first_rcp;
    logic          c_rise, q_rise, cancel_rise, rej, go, deny;
    logic [XW-1:0] cr_a, cr_b, price_sel, cr_left;

    function automatic logic [4:0] first_bit(input logic [4:0] v);
        first_bit = '0;
        for (int i = 0; i < 5; i++)
            if (v[i]) begin
                first_bit    = '0;
                first_bit[i] = 1'b1;
            end
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'b1000000;
            4'd1: seg7 = 7'b1111001;
            4'd2: seg7 = 7'b0100100;
            4'd3: seg7 = 7'b0110000;
            4'd4: seg7 = 7'b0011001;
            4'd5: seg7 = 7'b0010010;
            4'd6: seg7 = 7'b0000010;
            4'd7: seg7 = 7'b1111000;
            4'd8: seg7 = 7'b0000000;
            4'd9: seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign sel_rise    = {e, l, x, m, a} & ~sel_prev_q;
    assign c_rise      = C & ~ctl_prev_q[2];
    assign q_rise      = Q & ~ctl_prev_q[1];
    assign cancel_rise = cancel & ~ctl_prev_q[0];

    // Coins are credited C first, then Q, each against the ceiling; the
    // selection then sees the post-coin credit.
    always_comb begin
        cr_a = {1'b0, credit_q};
        rej  = 1'b0;
        if (c_rise) begin
            if (cr_a + XW'(COIN_LO) <= XW'(MAX_CREDIT)) cr_a = cr_a + XW'(COIN_LO);
            else rej = 1'b1;
        end
        cr_b = cr_a;
        if (q_rise) begin
            if (cr_b + XW'(COIN_HI) <= XW'(MAX_CREDIT)) cr_b = cr_b + XW'(COIN_HI);
            else rej = 1'b1;
        end
        price_sel = '0;
        rcp_sel   = '0;
        case (sel_rise)
            5'b10000: begin price_sel = XW'(PRICE_E); rcp_sel = RCP_E; end
            5'b01000: begin price_sel = XW'(PRICE_L); rcp_sel = RCP_L; end
            5'b00100: begin price_sel = XW'(PRICE_X); rcp_sel = RCP_X; end
            5'b00010: begin price_sel = XW'(PRICE_M); rcp_sel = RCP_M; end
            5'b00001: begin price_sel = XW'(PRICE_A); rcp_sel = RCP_A; end
            default: ;
        endcase
        go        = $onehot(sel_rise) && (cr_b >= price_sel);
        deny      = (|sel_rise) && !go;
        cr_left   = cr_b - price_sel;
        first_rcp = first_bit(rcp_sel);
    end

    always_ff @(posedge clk_50Mhz or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            credit_q        <= '0;
            change_amount_q <= '0;
            sel_prev_q      <= '0;
            ctl_prev_q      <= '0;
            valve_q         <= '0;
            rem_q           <= '0;
            cnt_q           <= '0;
            bebida_q        <= 1'b0;
            coin_reject_q   <= 1'b0;
            sel_denied_q    <= 1'b0;
            change_valid_q  <= 1'b0;
        end else begin
            sel_prev_q     <= {e, l, x, m, a};
            ctl_prev_q     <= {C, Q, cancel};
            coin_reject_q  <= 1'b0;
            sel_denied_q   <= 1'b0;
            change_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    credit_q      <= cr_b[CREDIT_W-1:0];
                    coin_reject_q <= rej;
                    sel_denied_q  <= deny;
                    if (go) begin
                        credit_q <= cr_left[CREDIT_W-1:0];
                        valve_q  <= first_rcp;
                        rem_q    <= rcp_sel & ~first_rcp;
                        cnt_q    <= STEP_LD;
                        state_q  <= STEP;
                    end else if (cancel_rise && cr_b != '0) begin
                        state_q <= CHANGE;
                    end
                end
                STEP: begin
                    coin_reject_q <= c_rise | q_rise;
                    if (valve_q != '0 && cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (rem_q != '0) begin
                        // Next set bit takes over on the following cycle, no gap.
                        valve_q <= first_bit(rem_q);
                        rem_q   <= rem_q & ~first_bit(rem_q);
                        cnt_q   <= STEP_LD;
                    end else begin
                        valve_q  <= '0;
                        bebida_q <= 1'b1;
                        cnt_q    <= DONE_LD;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    coin_reject_q <= c_rise | q_rise;
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        bebida_q <= 1'b0;
                        state_q  <= CHANGE;
                    end
                end
                CHANGE: begin
                    coin_reject_q <= c_rise | q_rise;
                    if (credit_q != '0) begin
                        change_valid_q  <= 1'b1;
                        change_amount_q <= credit_q;
                        credit_q        <= '0;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign {agua, cafe, leche, choco, azucar} = valve_q;
    assign bebidaLista   = bebida_q;
    assign coin_reject   = coin_reject_q;
    assign sel_denied    = sel_denied_q;
    assign change_valid  = change_valid_q;
    assign change_amount = change_amount_q;
    assign credit        = credit_q;
    assign hex1          = seg7(4'((32'(credit_q) / 100) % 10));
    assign hex2          = seg7(4'((32'(credit_q) / 1000) % 10));
endmodule

// File: tb/tb_maquina_cafe_param.sv
// Directed bench for maquina_cafe_param with short step/done timers.
module tb_maquina_cafe_param;
    logic clk_50Mhz = 1'b0;
    logic rst, e, l, x, m, a, C, Q, cancel;
    logic bebidaLista, agua, cafe, leche, choco, azucar;
    logic coin_reject, sel_denied, change_valid;
    logic [10:0] change_amount, credit;
    logic [6:0]  hex1, hex2;
    logic [4:0]  valves;
    int n_cmp = 0;
    int n_err = 0;
    int n_rej;
    logic [4:0] ev;

    localparam logic [6:0] SEG0 = 7'b1000000;
    localparam logic [6:0] SEG1 = 7'b1111001;
    localparam logic [6:0] SEG4 = 7'b0011001;
    localparam logic [6:0] SEG5 = 7'b0010010;

    maquina_cafe_param #(.STEP_CYCLES(4), .DONE_CYCLES(3)) dut (
        .clk_50Mhz(clk_50Mhz), .rst(rst), .e(e), .l(l), .x(x), .m(m), .a(a),
        .C(C), .Q(Q), .cancel(cancel), .bebidaLista(bebidaLista),
        .agua(agua), .cafe(cafe), .leche(leche), .choco(choco), .azucar(azucar),
        .coin_reject(coin_reject), .sel_denied(sel_denied), .change_valid(change_valid),
        .change_amount(change_amount), .credit(credit), .hex1(hex1), .hex2(hex2)
    );

    assign valves = {agua, cafe, leche, choco, azucar};
    always #5 clk_50Mhz = ~clk_50Mhz;

    task automatic tick;
        @(posedge clk_50Mhz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic coin(input bit hi);
        if (hi) Q = 1'b1; else C = 1'b1;
        tick;
        Q = 1'b0;
        C = 1'b0;
        tick;
    endtask

    initial begin
        rst = 1'b0;
        {e, l, x, m, a, C, Q, cancel} = '0;
        repeat (2) tick;
        chk("rst_credit", 32'(credit), 32'd0);
        chk("rst_hex1", 32'(hex1), 32'(SEG0));
        chk("rst_hex2", 32'(hex2), 32'(SEG0));
        chk("rst_valves", 32'(valves), 32'd0);
        chk("rst_bebida", 32'(bebidaLista), 32'd0);
        chk("rst_change_amt", 32'(change_amount), 32'd0);

        // C held high: one credit only
        rst = 1'b1;
        C = 1'b1;
        n_rej = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (coin_reject) n_rej++;
        end
        chk("hold_credit", 32'(credit), 32'd100);
        chk("hold_hex1", 32'(hex1), 32'(SEG1));
        chk("hold_hex2", 32'(hex2), 32'(SEG0));
        chk("hold_rejects", 32'(n_rej), 32'd0);
        C = 1'b0;
        tick;

        // mocaccino full sequence
        coin(1'b1);
        chk("q_credit", 32'(credit), 32'd600);
        coin(1'b0);
        chk("c_credit", 32'(credit), 32'd700);
        m = 1'b1;
        tick;
        m = 1'b0;
        chk("m_credit", 32'(credit), 32'd100);
        for (int i = 0; i < 20; i++) begin
            ev = 5'b10000 >> (i / 4);
            chk("m_valve", 32'(valves), 32'(ev));
            tick;
        end
        for (int j = 0; j < 3; j++) begin
            chk("m_bebida", 32'(bebidaLista), 32'd1);
            chk("m_done_valves", 32'(valves), 32'd0);
            tick;
        end
        chk("m_bebida_off", 32'(bebidaLista), 32'd0);
        chk("m_no_early_change", 32'(change_valid), 32'd0);
        tick;
        chk("m_change_valid", 32'(change_valid), 32'd1);
        chk("m_change_amt", 32'(change_amount), 32'd100);
        chk("m_credit_zero", 32'(credit), 32'd0);
        tick;
        chk("m_change_pulse_end", 32'(change_valid), 32'd0);
        chk("m_change_amt_hold", 32'(change_amount), 32'd100);

        // ceiling
        coin(1'b1); coin(1'b1); coin(1'b0); coin(1'b0); coin(1'b0); coin(1'b0);
        chk("ceil_1400", 32'(credit), 32'd1400);
        chk("ceil_hex1_4", 32'(hex1), 32'(SEG4));
        C = 1'b1;
        tick;
        chk("ceil_1500", 32'(credit), 32'd1500);
        chk("ceil_no_rej", 32'(coin_reject), 32'd0);
        chk("ceil_hex1_5", 32'(hex1), 32'(SEG5));
        chk("ceil_hex2_1", 32'(hex2), 32'(SEG1));
        C = 1'b0;
        tick;
        C = 1'b1;
        tick;
        chk("ceil_rej", 32'(coin_reject), 32'd1);
        chk("ceil_kept", 32'(credit), 32'd1500);
        C = 1'b0;
        tick;
        chk("ceil_rej_pulse_end", 32'(coin_reject), 32'd0);
        cancel = 1'b1;
        tick;
        cancel = 1'b0;
        tick;
        chk("ceil_refund_valid", 32'(change_valid), 32'd1);
        chk("ceil_refund_amt", 32'(change_amount), 32'd1500);
        chk("ceil_refund_credit", 32'(credit), 32'd0);

        // denied selections
        coin(1'b0);
        e = 1'b1;
        tick;
        chk("deny_low_pulse", 32'(sel_denied), 32'd1);
        chk("deny_low_credit", 32'(credit), 32'd100);
        chk("deny_low_valves", 32'(valves), 32'd0);
        e = 1'b0;
        tick;
        chk("deny_pulse_end", 32'(sel_denied), 32'd0);
        l = 1'b1; m = 1'b1;
        tick;
        chk("deny_two_pulse", 32'(sel_denied), 32'd1);
        chk("deny_two_credit", 32'(credit), 32'd100);
        l = 1'b0; m = 1'b0;
        tick;
        coin(1'b1); coin(1'b1);
        l = 1'b1; m = 1'b1;
        tick;
        chk("deny_two_rich_pulse", 32'(sel_denied), 32'd1);
        chk("deny_two_rich_credit", 32'(credit), 32'd1100);
        chk("deny_two_rich_valves", 32'(valves), 32'd0);
        l = 1'b0; m = 1'b0;
        tick;

        // C then Q same cycle: C fits, Q exceeds ceiling
        C = 1'b1; Q = 1'b1;
        tick;
        chk("cq_credit", 32'(credit), 32'd1200);
        chk("cq_rej", 32'(coin_reject), 32'd1);
        C = 1'b0; Q = 1'b0;
        tick;
        cancel = 1'b1;
        tick;
        cancel = 1'b0;
        tick;
        chk("cq_refund_amt", 32'(change_amount), 32'd1200);

        // cancel refund, then cancel at zero credit
        coin(1'b1);
        cancel = 1'b1;
        tick;
        cancel = 1'b0;
        tick;
        chk("cancel_valid", 32'(change_valid), 32'd1);
        chk("cancel_amt", 32'(change_amount), 32'd500);
        chk("cancel_credit", 32'(credit), 32'd0);
        tick;
        chk("cancel_pulse_end", 32'(change_valid), 32'd0);
        cancel = 1'b1;
        tick;
        cancel = 1'b0;
        chk("cancel0_no_pulse_a", 32'(change_valid), 32'd0);
        tick;
        chk("cancel0_no_pulse_b", 32'(change_valid), 32'd0);
        tick;
        chk("cancel0_no_pulse_c", 32'(change_valid), 32'd0);
        chk("cancel0_amt_hold", 32'(change_amount), 32'd500);

        // coin and select same cycle: 500 credited, espresso 300 bought
        Q = 1'b1; e = 1'b1;
        tick;
        Q = 1'b0; e = 1'b0;
        chk("coinsel_credit", 32'(credit), 32'd200);
        chk("coinsel_agua", 32'(valves), 32'b10000);
        for (int k = 0; k < 40 && !change_valid; k++) tick;
        chk("coinsel_change_seen", 32'(change_valid), 32'd1);
        chk("coinsel_change_amt", 32'(change_amount), 32'd200);
        tick;

        // async reset during cafe step
        coin(1'b1); coin(1'b1);
        l = 1'b1;
        tick;
        l = 1'b0;
        chk("latte_credit", 32'(credit), 32'd500);
        repeat (4) tick;
        chk("latte_cafe", 32'(valves), 32'b01000);
        #2 rst = 1'b0;
        #1;
        chk("arst_valves", 32'(valves), 32'd0);
        chk("arst_credit", 32'(credit), 32'd0);
        chk("arst_hex1", 32'(hex1), 32'(SEG0));
        tick;
        rst = 1'b1;
        tick;
        chk("arst_post_valves", 32'(valves), 32'd0);
        chk("arst_post_change", 32'(change_valid), 32'd0);
        coin(1'b0);
        chk("arst_idle_credit", 32'(credit), 32'd100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
